// File: rtl/d_cache_sa.sv
// d_cache_sa: set-associative, write-back, write-allocate L1 data cache with one outstanding miss.
// Defining D_CACHE_FLUSH_EN adds a flush engine (flush_req / flush_done).
module d_cache_sa #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int SETS   = 64,
   parameter int WAYS   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_hit,
   output logic              l2_req_valid,
   input  logic              l2_req_ready,
   output logic              l2_req_we,
   output logic [ADDR_W-1:0] l2_req_addr,
   output logic [DATA_W-1:0] l2_req_wdata,
   input  logic              l2_resp_valid,
   input  logic [DATA_W-1:0] l2_resp_data
`ifdef D_CACHE_FLUSH_EN
   ,
   input  logic              flush_req,
   output logic              flush_done
`endif
);

   localparam int OFF_W = $clog2(DATA_W / 8);
   localparam int IDX_W = $clog2(SETS);
   localparam int WAY_W = $clog2(WAYS);
   localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_WB, S_FILL_REQ, S_FILL_WAIT, S_RESP
`ifdef D_CACHE_FLUSH_EN
      , S_FL_SCAN, S_FL_WB
`endif
   } state_t;

   state_t             state_reg;
   logic               ready_reg;
   logic               op_we_reg;
   logic [TAG_W-1:0]   op_tag_reg;
   logic [IDX_W-1:0]   op_idx_reg;
   logic [DATA_W-1:0]  op_wdata_reg;
   logic [WAY_W-1:0]   vway_reg;

   logic [TAG_W-1:0]   tag_mem  [SETS][WAYS];
   logic [DATA_W-1:0]  data_mem [SETS][WAYS];
   logic [WAYS-1:0]    valid_reg [SETS];
   logic [WAYS-1:0]    dirty_reg [SETS];
   logic [WAY_W-1:0]   rr_reg    [SETS];

   logic [WAYS-1:0]    way_hit;
   logic               hit_any;
   logic [WAY_W-1:0]   hit_way;
   logic               have_inv;
   logic [WAY_W-1:0]   inv_way;
   logic [WAY_W-1:0]   victim;
   logic               mem_we;
   logic [WAY_W-1:0]   mem_way;
   logic [DATA_W-1:0]  mem_data;

   wire unused_offset = &{1'b0, req_addr[OFF_W-1:0]};

   genvar gi;
   generate
      for (gi = 0; gi < WAYS; gi++) begin : g_cmp
         assign way_hit[gi] = valid_reg[op_idx_reg][gi] && (tag_mem[op_idx_reg][gi] == op_tag_reg);
      end
   endgenerate
   assign hit_any = |way_hit;

   // Lowest-index invalid way wins over the round-robin pointer.
   always_comb begin
      hit_way  = '0;
      have_inv = 1'b0;
      inv_way  = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (way_hit[w]) hit_way = WAY_W'(w);
         if (!valid_reg[op_idx_reg][w]) begin
            have_inv = 1'b1;
            inv_way  = WAY_W'(w);
         end
      end
      victim = have_inv ? inv_way : rr_reg[op_idx_reg];
   end

   always_comb begin
      mem_we   = 1'b0;
      mem_way  = hit_way;
      mem_data = op_wdata_reg;
      if (state_reg == S_LOOKUP && hit_any && op_we_reg) begin
         mem_we = 1'b1;
      end else if (state_reg == S_FILL_WAIT && l2_resp_valid) begin
         mem_we   = 1'b1;
         mem_way  = vway_reg;
         mem_data = op_we_reg ? op_wdata_reg : l2_resp_data;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         tag_mem[op_idx_reg][mem_way]  <= op_tag_reg;
         data_mem[op_idx_reg][mem_way] <= mem_data;
      end
   end

`ifdef D_CACHE_FLUSH_EN
   logic [IDX_W+WAY_W-1:0] fcnt_reg;
   logic [IDX_W-1:0]       fset;
   logic [WAY_W-1:0]       fway;
   logic                   fl_step;
   assign fset    = fcnt_reg[IDX_W+WAY_W-1:WAY_W];
   assign fway    = fcnt_reg[WAY_W-1:0];
   assign fl_step = (state_reg == S_FL_SCAN && !(valid_reg[fset][fway] && dirty_reg[fset][fway])) ||
                    (state_reg == S_FL_WB && l2_req_ready);
   assign req_ready = ready_reg & ~flush_req;
`else
   assign req_ready = ready_reg;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= S_IDLE;
         ready_reg    <= 1'b0;
         op_we_reg    <= 1'b0;
         op_tag_reg   <= '0;
         op_idx_reg   <= '0;
         op_wdata_reg <= '0;
         vway_reg     <= '0;
         resp_valid   <= 1'b0;
         resp_rdata   <= '0;
         resp_hit     <= 1'b0;
         l2_req_valid <= 1'b0;
         l2_req_we    <= 1'b0;
         l2_req_addr  <= '0;
         l2_req_wdata <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_reg[s] <= '0;
            dirty_reg[s] <= '0;
            rr_reg[s]    <= '0;
         end
`ifdef D_CACHE_FLUSH_EN
         fcnt_reg   <= '0;
         flush_done <= 1'b0;
`endif
      end else begin
         resp_valid <= 1'b0;
         resp_hit   <= 1'b0;
`ifdef D_CACHE_FLUSH_EN
         flush_done <= 1'b0;
`endif
         case (state_reg)
            S_IDLE: begin
`ifdef D_CACHE_FLUSH_EN
               if (flush_req) begin
                  ready_reg <= 1'b0;
                  fcnt_reg  <= '0;
                  state_reg <= S_FL_SCAN;
               end else
`endif
               if (req_valid && ready_reg) begin
                  ready_reg    <= 1'b0;
                  op_we_reg    <= req_we;
                  op_tag_reg   <= req_addr[ADDR_W-1:OFF_W+IDX_W];
                  op_idx_reg   <= req_addr[OFF_W+IDX_W-1:OFF_W];
                  op_wdata_reg <= req_wdata;
                  state_reg    <= S_LOOKUP;
               end else begin
                  ready_reg <= 1'b1;
               end
            end
            S_LOOKUP: begin
               if (hit_any) begin
                  resp_valid <= 1'b1;
                  resp_hit   <= 1'b1;
                  resp_rdata <= op_we_reg ? op_wdata_reg : data_mem[op_idx_reg][hit_way];
                  if (op_we_reg) dirty_reg[op_idx_reg][hit_way] <= 1'b1;
                  state_reg  <= S_RESP;
               end else begin
                  vway_reg     <= victim;
                  l2_req_valid <= 1'b1;
                  if (!have_inv) rr_reg[op_idx_reg] <= rr_reg[op_idx_reg] + 1'b1;
                  if (valid_reg[op_idx_reg][victim] && dirty_reg[op_idx_reg][victim]) begin
                     l2_req_we    <= 1'b1;
                     l2_req_addr  <= {tag_mem[op_idx_reg][victim], op_idx_reg, {OFF_W{1'b0}}};
                     l2_req_wdata <= data_mem[op_idx_reg][victim];
                     state_reg    <= S_WB;
                  end else begin
                     l2_req_we   <= 1'b0;
                     l2_req_addr <= {op_tag_reg, op_idx_reg, {OFF_W{1'b0}}};
                     state_reg   <= S_FILL_REQ;
                  end
               end
            end
            S_WB: begin
               if (l2_req_ready) begin
                  l2_req_we   <= 1'b0;
                  l2_req_addr <= {op_tag_reg, op_idx_reg, {OFF_W{1'b0}}};
                  state_reg   <= S_FILL_REQ;
               end
            end
            S_FILL_REQ: begin
               if (l2_req_ready) begin
                  l2_req_valid <= 1'b0;
                  state_reg    <= S_FILL_WAIT;
               end
            end
            S_FILL_WAIT: begin
               if (l2_resp_valid) begin
                  valid_reg[op_idx_reg][vway_reg] <= 1'b1;
                  dirty_reg[op_idx_reg][vway_reg] <= op_we_reg;
                  resp_valid <= 1'b1;
                  resp_rdata <= op_we_reg ? op_wdata_reg : l2_resp_data;
                  state_reg  <= S_RESP;
               end
            end
            S_RESP: begin
               ready_reg <= 1'b1;
               state_reg <= S_IDLE;
            end
`ifdef D_CACHE_FLUSH_EN
            S_FL_SCAN: begin
               if (valid_reg[fset][fway] && dirty_reg[fset][fway]) begin
                  l2_req_valid <= 1'b1;
                  l2_req_we    <= 1'b1;
                  l2_req_addr  <= {tag_mem[fset][fway], fset, {OFF_W{1'b0}}};
                  l2_req_wdata <= data_mem[fset][fway];
                  state_reg    <= S_FL_WB;
               end
            end
            S_FL_WB: begin
               if (l2_req_ready) l2_req_valid <= 1'b0;
            end
`endif
            default: state_reg <= S_IDLE;
         endcase
`ifdef D_CACHE_FLUSH_EN
         // Each visited line is dropped once any pending write-back completes.
         if (fl_step) begin
            valid_reg[fset][fway] <= 1'b0;
            dirty_reg[fset][fway] <= 1'b0;
            if (fcnt_reg == '1) begin
               flush_done <= 1'b1;
               ready_reg  <= 1'b1;
               state_reg  <= S_IDLE;
               for (int s = 0; s < SETS; s++) rr_reg[s] <= '0;
            end else begin
               state_reg <= S_FL_SCAN;
               fcnt_reg  <= fcnt_reg + 1'b1;
            end
         end
`endif
      end
   end

endmodule
